// File: rtl/kanji_rom_fetch.sv
// kanji_rom_fetch: read-return stage behind the Kanji/Hangul font device.
// Turns the device's one-shot RAM request into a handshaked byte read on the
// shared SDRAM port. It holds the CPU in wait until the byte returns, then
// presents the byte for the rest of the I/O read cycle.
// Optional feature macro: KANJI_PREFETCH_EN (one-entry next-byte prefetch buffer).
module kanji_rom_fetch #(
  parameter int unsigned ADDR_W  = 27,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_dev_cs,
  input  logic [ADDR_W-1:0] i_dev_addr,
  input  logic              i_cpu_rd,
  output logic              o_cpu_wait,
  output logic [7:0]        o_cpu_data,
  output logic              o_cpu_data_oe,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic              i_mem_valid,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_timeout_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  // Last count value before the read is abandoned (ISSUE+WAIT spans TIMEOUT cycles).
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  state_e            r_state, w_state_nxt;
  logic              r_mem_rd, w_mem_rd_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [7:0]        r_cpu_data, w_cpu_data_nxt;
  logic [15:0]       r_tcnt, w_tcnt_nxt;
  logic              r_err, w_err_nxt;

  logic              w_busy;
  logic              w_data_in;
  logic              w_tmo;
  logic              w_dev_wait;
  logic              w_busy_demand;

`ifdef KANJI_PREFETCH_EN
  logic              r_is_pf, w_is_pf_nxt;          // outstanding read is a prefetch
  logic              r_pend, w_pend_nxt;            // demand queued behind a prefetch
  logic [ADDR_W-1:0] r_pend_addr, w_pend_addr_nxt;
  logic [ADDR_W-1:0] r_pf_addr, w_pf_addr_nxt;
  logic [7:0]        r_pf_data, w_pf_data_nxt;
  logic              r_pf_valid, w_pf_valid_nxt;
  logic              r_last_ok, w_last_ok_nxt;      // last demand read returned real data

  logic              w_hit;
  logic              w_pf_claim;
  logic              w_pf_miss;
  logic              w_as_pf;
  logic [ADDR_W-1:0] w_next_addr;

  // Next byte wraps inside the 32-byte glyph row, like the device auto-increment.
  assign w_next_addr = {r_mem_addr[ADDR_W-1:5], r_mem_addr[4:0] + 5'd1};
  assign w_hit       = (r_state == StIdle) && r_pf_valid && (i_dev_addr == r_pf_addr);
  assign w_pf_claim  = r_is_pf && !r_pend && i_dev_cs && (i_dev_addr == r_pf_addr);
  assign w_pf_miss   = r_is_pf && !r_pend && i_dev_cs && (i_dev_addr != r_pf_addr);
  assign w_as_pf     = r_is_pf && !w_pf_claim;
`endif

  assign w_busy    = (r_state == StIssue) || (r_state == StWait);
  assign w_data_in = ((r_state == StIssue) && i_mem_ack && i_mem_valid) ||
                     ((r_state == StWait) && i_mem_valid);
  // Returned data wins over an expiring count; a bare ack does not.
  assign w_tmo     = w_busy && !w_data_in && (r_tcnt == TmoLast);

`ifdef KANJI_PREFETCH_EN
  assign w_dev_wait    = i_dev_cs && !w_hit;
  assign w_busy_demand = w_busy && (!r_is_pf || r_pend);
`else
  assign w_dev_wait    = i_dev_cs;
  assign w_busy_demand = w_busy;
`endif

  assign o_cpu_wait    = w_dev_wait || w_busy_demand;
  assign o_cpu_data    = r_cpu_data;
  assign o_cpu_data_oe = (r_state == StDone);
  assign o_mem_rd      = r_mem_rd;
  assign o_mem_addr    = r_mem_addr;
  assign o_timeout_err = r_err;

  // State register; async reset also drops mem_rd and cpu_wait mid-transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '1;
      r_cpu_data  <= 8'hFF;
      r_tcnt      <= '0;
      r_err       <= 1'b0;
`ifdef KANJI_PREFETCH_EN
      r_is_pf     <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pf_addr   <= '0;
      r_pf_data   <= 8'hFF;
      r_pf_valid  <= 1'b0;
      r_last_ok   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_mem_rd    <= w_mem_rd_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_cpu_data  <= w_cpu_data_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_err       <= w_err_nxt;
`ifdef KANJI_PREFETCH_EN
      r_is_pf     <= w_is_pf_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_pf_addr   <= w_pf_addr_nxt;
      r_pf_data   <= w_pf_data_nxt;
      r_pf_valid  <= w_pf_valid_nxt;
      r_last_ok   <= w_last_ok_nxt;
`endif
    end
  end

  // Next-state logic: request issue, ack/data handshake, timeout, read-cycle hold.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_rd_nxt    = r_mem_rd;
    w_mem_addr_nxt  = r_mem_addr;
    w_cpu_data_nxt  = r_cpu_data;
    w_tcnt_nxt      = r_tcnt;
    w_err_nxt       = r_err;
`ifdef KANJI_PREFETCH_EN
    w_is_pf_nxt     = r_is_pf;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_pf_addr_nxt   = r_pf_addr;
    w_pf_data_nxt   = r_pf_data;
    w_pf_valid_nxt  = r_pf_valid;
    w_last_ok_nxt   = r_last_ok;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_dev_cs) begin
`ifdef KANJI_PREFETCH_EN
          if (w_hit) begin
            w_cpu_data_nxt = r_pf_data;
            w_pf_valid_nxt = 1'b0;
            w_last_ok_nxt  = 1'b1;
            w_state_nxt    = StDone;
          end else begin
            w_pf_valid_nxt = 1'b0;
            w_mem_addr_nxt = i_dev_addr;
            w_mem_rd_nxt   = 1'b1;
            w_tcnt_nxt     = '0;
            w_state_nxt    = StIssue;
          end
`else
          w_mem_addr_nxt = i_dev_addr;
          w_mem_rd_nxt   = 1'b1;
          w_tcnt_nxt     = '0;
          w_state_nxt    = StIssue;
`endif
        end
      end
      StIssue, StWait: begin
        w_tcnt_nxt = r_tcnt + 16'd1;
`ifdef KANJI_PREFETCH_EN
        if (w_pf_claim) begin
          w_is_pf_nxt = 1'b0;
        end else if (w_pf_miss) begin
          w_pend_nxt      = 1'b1;
          w_pend_addr_nxt = i_dev_addr;
        end
`endif
        if (w_data_in || w_tmo) begin
          w_mem_rd_nxt = 1'b0;
`ifdef KANJI_PREFETCH_EN
          if (w_as_pf) begin
            w_is_pf_nxt = 1'b0;
            if (r_pend || w_pf_miss) begin
              // Drop the prefetch result and start the queued demand read.
              w_pend_nxt     = 1'b0;
              w_mem_addr_nxt = r_pend ? r_pend_addr : i_dev_addr;
              w_mem_rd_nxt   = 1'b1;
              w_tcnt_nxt     = '0;
              w_state_nxt    = StIssue;
            end else begin
              w_pf_valid_nxt = w_data_in;
              w_pf_data_nxt  = i_mem_rdata;
              w_state_nxt    = StIdle;
            end
          end else begin
            w_last_ok_nxt  = w_data_in;
            w_cpu_data_nxt = w_data_in ? i_mem_rdata : 8'hFF;
            w_err_nxt      = r_err || w_tmo;
            w_state_nxt    = StDone;
          end
`else
          w_cpu_data_nxt = w_data_in ? i_mem_rdata : 8'hFF;
          w_err_nxt      = r_err || w_tmo;
          w_state_nxt    = StDone;
`endif
        end else if ((r_state == StIssue) && i_mem_ack) begin
          w_mem_rd_nxt = 1'b0;
          w_state_nxt  = StWait;
        end
      end
      StDone: begin
        if (!i_cpu_rd) begin
`ifdef KANJI_PREFETCH_EN
          if (r_last_ok) begin
            w_pf_addr_nxt  = w_next_addr;
            w_mem_addr_nxt = w_next_addr;
            w_mem_rd_nxt   = 1'b1;
            w_tcnt_nxt     = '0;
            w_is_pf_nxt    = 1'b1;
            w_pf_valid_nxt = 1'b0;
            w_state_nxt    = StIssue;
          end else begin
            w_state_nxt = StIdle;
          end
`else
          w_state_nxt = StIdle;
`endif
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: doc/kanji_rom_fetch.md
Name: kanji_rom_fetch

Overview:
- Read-return stage directly downstream of the Kanji/Hangul font device.
- Consumes the device's one-shot RAM request (ram_cs pulse plus 27-bit ram_addr) and issues a handshaked byte read to the shared SDRAM controller port.
- Holds the CPU in wait until the byte returns, then drives the byte onto the CPU read-data path for the rest of the I/O read cycle.

Parameters:
- ADDR_W, 27: width of dev_addr and mem_addr.
- TIMEOUT, 255: cycles allowed in ISSUE+WAIT before the read is abandoned; legal range 2..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- dev_cs  in  1  one-cycle request pulse from the font device
- dev_addr  in  ADDR_W  absolute byte address; valid only when dev_cs=1
- cpu_rd  in  1  CPU I/O read strobe; high for the whole read cycle
- cpu_wait  out  1  wait request to the CPU
- cpu_data  out  8  returned byte
- cpu_data_oe  out  1  cpu_data is valid for the bus mux
- mem_rd  out  1  read request to the SDRAM port
- mem_addr  out  ADDR_W  read address
- mem_ack  in  1  request accepted
- mem_valid  in  1  mem_rdata valid; single-cycle pulse
- mem_rdata  in  8  read data
- timeout_err  out  1  sticky; set on any timeout; cleared only by reset

Behaviour:
- Reset values: cpu_wait=0, cpu_data=8'hFF, cpu_data_oe=0, mem_rd=0, mem_addr=all-ones, timeout_err=0, state=IDLE, timeout counter=0. The asynchronous reset drops mem_rd and cpu_wait immediately, including mid-transaction.
- States: IDLE, ISSUE, WAIT, DONE.
- cpu_wait = dev_cs (combinational, so the request cycle is covered) OR state in {ISSUE, WAIT}.
- IDLE:
  - On dev_cs=1: latch dev_addr into mem_addr, set mem_rd=1, go to ISSUE.
  - dev_cs in any other state is ignored; the latched address is not disturbed.
- ISSUE:
  - mem_rd stays high and mem_addr stays stable until mem_ack=1 is sampled.
  - On mem_ack=1: mem_rd=0 next cycle, go to WAIT.
  - If mem_ack and mem_valid are both high in the same cycle: latch mem_rdata and go directly to DONE.
- WAIT: on mem_valid=1, latch mem_rdata into cpu_data and go to DONE.
- Timeout counter:
  - Clears on entry to ISSUE and increments every cycle in ISSUE or WAIT.
  - When it equals TIMEOUT-1 without completion: cpu_data=8'hFF, mem_rd=0, timeout_err=1, go to DONE.
- DONE:
  - cpu_data_oe=1 while cpu_rd=1.
  - The first cycle with cpu_rd=0: cpu_data_oe=0 next cycle and return to IDLE.
  - cpu_data keeps its last value after leaving DONE.
- mem_valid or mem_ack sampled in IDLE or DONE (for example, a late response after a timeout) is discarded with no state change.
- Latency (no prefetch): dev_cs at cycle 0, mem_rd high at cycle 1, minimum one cycle to DONE after mem_valid. cpu_data_oe goes high in the cycle after mem_valid is sampled.

Optional Feature:
- Macro: KANJI_PREFETCH_EN.
- When defined:
  - Adds a one-entry prefetch buffer: pf_addr, pf_data, pf_valid, pf_busy.
  - Trigger: on DONE→IDLE after a successful (non-timeout) read, the block issues a background read of pf_addr = (mem_addr & ~'h1F) | ((mem_addr+1) & 'h1F). This wraps within the 32-byte glyph row, matching the device's auto-increment.
  - Hit (dev_cs with dev_addr==pf_addr and pf_valid=1): cpu_wait stays 0, cpu_data=pf_data, go to DONE in one cycle, then prefetch the next address.
  - In-flight match (dev_cs with dev_addr==pf_addr and pf_busy=1): treat as a demand read already in WAIT; cpu_wait=1 until data arrives.
  - Mismatch: pf_valid is cleared. If the prefetch is in flight, let it complete, discard its data, then issue the demand read; cpu_wait stays high throughout.
  - A prefetch timeout clears pf_valid and does not set timeout_err.
- When not defined: no prefetch logic, and every dev_cs results in a demand read.

Test Plan:
- Basic read: dev_cs with addr 0x0020041; mem_ack after 2 cycles; mem_valid with 0x5A after 3 more → mem_addr=0x0020041, cpu_wait high until then, cpu_data=0x5A, oe drops one cycle after cpu_rd falls.
- Combined ack and valid: mem_ack and mem_valid both high in the cycle after mem_rd, data 0xC3 → ISSUE→DONE, cpu_data=0xC3, no WAIT cycle.
- Timeout: TIMEOUT=8, mem_ack never asserted → after 8 cycles cpu_data=0xFF, timeout_err=1, mem_rd=0. A later mem_valid with 0x11 is ignored and cpu_data stays 0xFF.
- Busy collision and reset: a second dev_cs (addr 0x1000) during WAIT is ignored and mem_addr unchanged. Asserting reset mid-WAIT forces mem_rd=0, cpu_wait=0, state IDLE in the same cycle.
- Prefetch hit and wrap (KANJI_PREFETCH_EN): read 0x000003F returns 0x77, then a background read of 0x0000020 returns 0x88. dev_cs at 0x0000020 gives cpu_wait=0 throughout and cpu_data=0x88.
- Prefetch miss (KANJI_PREFETCH_EN): prefetch in flight for 0x21 while dev_cs arrives for 0x800 → cpu_wait held; prefetch data discarded; demand read for 0x800 returns its data.
